// File: rtl/func_select_fsm_pkg.sv
// Function codes, FSM state encodings and the browse-order lookup.
// The code and state values are shared with the downstream LED decoder stage.
package func_select_fsm_pkg;

  localparam logic [2:0] FUNC_NONE = 3'b000;
  localparam logic [2:0] FUNC_1    = 3'b001;
  localparam logic [2:0] FUNC_3    = 3'b011;
  localparam logic [2:0] FUNC_4    = 3'b100;
  localparam logic [2:0] FUNC_6    = 3'b110;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_BROWSE = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;

  // Browse order 1 -> 3 -> 4 -> 6 -> 1; anything off the ring restarts at 1.
  function automatic logic [2:0] succ(input logic [2:0] code);
    case (code)
      FUNC_1:  succ = FUNC_3;
      FUNC_3:  succ = FUNC_4;
      FUNC_4:  succ = FUNC_6;
      FUNC_6:  succ = FUNC_1;
      default: succ = FUNC_1;
    endcase
  endfunction

endpackage

// File: rtl/func_select_fsm_btn_debounce.sv
// Per-button 2-flop synchroniser, stability counter and registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Accept the new level; only a press (new level 1) is reported.
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_pulse  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/func_select_fsm.sv
// Operator front-end: debounced next/confirm/cancel buttons drive a browse/confirm FSM
// that latches the chosen function code onto func for the LED decoder.
module func_select_fsm
  import func_select_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  output logic [2:0] func,
  output logic [2:0] preview,
  output logic       active,
  output logic [1:0] dbg_state
);

  logic       w_next;
  logic       w_confirm;
  logic       w_cancel;
  logic [1:0] r_state;
  logic [2:0] r_func;
  logic [2:0] r_preview;
  logic       r_active;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_next (
    .i_clk(clk), .i_rst(reset), .i_btn(btn_next), .o_pulse(w_next)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_confirm (
    .i_clk(clk), .i_rst(reset), .i_btn(btn_confirm), .o_pulse(w_confirm)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_cancel (
    .i_clk(clk), .i_rst(reset), .i_btn(btn_cancel), .o_pulse(w_cancel)
  );

  // Priority cancel > confirm > next: a lower pulse in the same cycle is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_func    <= FUNC_NONE;
      r_preview <= FUNC_NONE;
      r_active  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next && !w_confirm && !w_cancel) begin
            r_state   <= S_BROWSE;
            r_preview <= FUNC_1;
          end
        end
        S_BROWSE: begin
          if (w_cancel) begin
            r_state   <= r_active ? S_RUN : S_IDLE;
            r_preview <= FUNC_NONE;
          end else if (w_confirm) begin
            r_state   <= S_RUN;
            r_func    <= r_preview;
            r_active  <= 1'b1;
            r_preview <= FUNC_NONE;
          end else if (w_next) begin
            r_preview <= succ(r_preview);
          end
        end
        S_RUN: begin
          if (w_cancel) begin
            r_state  <= S_IDLE;
            r_func   <= FUNC_NONE;
            r_active <= 1'b0;
          end else if (w_next && !w_confirm) begin
            r_state   <= S_BROWSE;
            r_preview <= succ(r_func);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_func    <= FUNC_NONE;
          r_preview <= FUNC_NONE;
          r_active  <= 1'b0;
        end
      endcase
    end
  end

  assign func      = r_func;
  assign preview   = r_preview;
  assign active    = r_active;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_func_select_fsm.sv
// Directed bench for func_select_fsm with DEBOUNCE_CYCLES=4.
module tb_func_select_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next;
  logic       btn_confirm;
  logic       btn_cancel;
  logic [2:0] func;
  logic [2:0] preview;
  logic       active;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  func_select_fsm #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_confirm(btn_confirm),
    .btn_cancel(btn_cancel), .func(func), .preview(preview), .active(active),
    .dbg_state(dbg_state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m = {cancel, confirm, next}; hold high for 'hold' cycles then let the release settle.
  task automatic press(input logic [2:0] m, input int hold);
    btn_next    = m[0];
    btn_confirm = m[1];
    btn_cancel  = m[2];
    tick(hold);
    btn_next    = 1'b0;
    btn_confirm = 1'b0;
    btn_cancel  = 1'b0;
    tick(8);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] f,
                           input logic [2:0] p, input logic a);
    check({tag, ".state"},   {2'b00, dbg_state}, {2'b00, st});
    check({tag, ".func"},    {1'b0, func},       {1'b0, f});
    check({tag, ".preview"}, {1'b0, preview},    {1'b0, p});
    check({tag, ".active"},  {3'b000, active},   {3'b000, a});
  endtask

  initial begin
    reset = 1'b1;
    btn_next = 1'b0;
    btn_confirm = 1'b0;
    btn_cancel = 1'b0;
    tick(3);
    check_all("reset", 2'b00, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;

    // 3-cycle glitch never reaches the debounce threshold.
    press(3'b001, 3);
    tick(4);
    check_all("glitch", 2'b00, 3'b000, 3'b000, 1'b0);

    // Pulse after edge 6, FSM update on edge 7.
    btn_next = 1'b1;
    tick(6);
    check("latency.edge6", {1'b0, preview}, 4'h0);
    tick(1);
    check("latency.edge7", {1'b0, preview}, 4'h1);
    tick(3);
    btn_next = 1'b0;
    tick(8);
    check_all("held_one_pulse", 2'b01, 3'b000, 3'b001, 1'b0);

    press(3'b001, 10);
    check("seq.3", {1'b0, preview}, 4'h3);
    press(3'b001, 10);
    check("seq.4", {1'b0, preview}, 4'h4);
    press(3'b001, 10);
    check("seq.6", {1'b0, preview}, 4'h6);
    press(3'b001, 10);
    check("seq.wrap1", {1'b0, preview}, 4'h1);

    // Reset between edges clears outputs without a clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("async_reset", 2'b00, 3'b000, 3'b000, 1'b0);
    tick(1);
    reset = 1'b0;

    press(3'b001, 10);
    press(3'b001, 10);
    check("t5.preview3", {1'b0, preview}, 4'h3);
    press(3'b010, 10);
    check_all("t5.confirm", 2'b10, 3'b011, 3'b000, 1'b1);
    press(3'b001, 10);
    check_all("t5.next_run", 2'b01, 3'b011, 3'b100, 1'b1);
    press(3'b100, 10);
    check_all("t5.cancel_to_run", 2'b10, 3'b011, 3'b000, 1'b1);

    press(3'b001, 10);
    check("t6.browse", {1'b0, preview}, 4'h4);
    press(3'b110, 10);
    check_all("t6.cancel_wins", 2'b10, 3'b011, 3'b000, 1'b1);
    press(3'b100, 10);
    check_all("t6.cancel_run", 2'b00, 3'b000, 3'b000, 1'b0);

    press(3'b010, 10);
    check_all("idle_confirm_ignored", 2'b00, 3'b000, 3'b000, 1'b0);
    press(3'b100, 10);
    check_all("idle_cancel_ignored", 2'b00, 3'b000, 3'b000, 1'b0);

    // Button held through reset release must debounce from scratch.
    btn_next = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    check("held_reset.edge6", {1'b0, preview}, 4'h0);
    tick(1);
    check("held_reset.edge7", {1'b0, preview}, 4'h1);
    btn_next = 1'b0;
    tick(10);
    check_all("held_reset.final", 2'b01, 3'b000, 3'b001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
